// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_e;

  localparam int ARB_ID_IFU = 0;
  localparam int ARB_ID_LSU = 1;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam logic [7:0] PERF_ARB_WAIT = 8'h01;

  // Memory-side ID tagging each master's transaction.
  function automatic int owner_id(input owner_e owner);
    case (owner)
      OWN_LSU: owner_id = ARB_ID_LSU;
      default: owner_id = ARB_ID_IFU;
    endcase
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_chk.sv
// Protocol checks and perf coverage for the read arbiter; no effect on the datapath.
module axi_rd_arbiter_chk
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ID_W = 4
) (
  input logic            clk,
  input logic            rstn,
  input state_e          state,
  input logic            mem_rvalid,
  input logic            mem_rready,
  input logic            mem_rlast,
  input logic [1:0]      mem_rresp,
  input logic [ID_W-1:0] mem_rid,
  input logic [ID_W-1:0] own_id,
  input logic [7:0]      beat_cnt,
  input logic [7:0]      arlen,
  input logic [7:0]      perf_code
);

  rid_matches_owner: assert property (@(posedge clk) disable iff (!rstn)
    (state == S_R && mem_rvalid) |-> (mem_rid == own_id));

  // beat_cnt holds beats already taken, so the last beat arrives with beat_cnt == arlen.
  beat_count_at_last: assert property (@(posedge clk) disable iff (!rstn)
    (state == S_R && mem_rvalid && mem_rready && mem_rlast) |-> (beat_cnt == arlen));

  no_rvalid_outside_r: assert property (@(posedge clk) disable iff (!rstn)
    (state != S_R) |-> !mem_rvalid);

  error_resp_seen: cover property (@(posedge clk) disable iff (!rstn)
    mem_rvalid && (mem_rresp != AXI_RESP_OKAY));

  perf_arb_wait: cover property (@(posedge clk) disable iff (!rstn)
    perf_code == PERF_ARB_WAIT);

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; priority register moves away from the master that just finished.
module rr_arbiter2 (
  input  logic clk,
  input  logic rstn,
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic upd_en,
  input  logic upd_lsu,
  output logic gnt_ifu,
  output logic gnt_lsu
);

  logic prio_lsu_r;

  // Grant the sole requester, or the priority holder on a tie.
  always_comb begin
    gnt_lsu = req_lsu && (prio_lsu_r || !req_ifu);
    gnt_ifu = req_ifu && (!prio_lsu_r || !req_lsu);
  end

  // Priority register: LSU first out of reset, flips on each completed transaction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio_lsu_r <= 1'b1;
    end else if (upd_en) begin
      prio_lsu_r <= !upd_lsu;
    end else begin
      prio_lsu_r <= prio_lsu_r;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Merges IFU and LSU AXI read masters onto one memory read port, one transaction at a time.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic [2:0]        ifu_arsize,
  input  logic [7:0]        ifu_arlen,
  input  logic [1:0]        ifu_arburst,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [2:0]        lsu_arsize,
  input  logic [7:0]        lsu_arlen,
  input  logic [1:0]        lsu_arburst,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rlast,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic [2:0]        mem_arsize,
  output logic [7:0]        mem_arlen,
  output logic [1:0]        mem_arburst,
  output logic [ID_W-1:0]   mem_arid,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rlast,
  input  logic [ID_W-1:0]   mem_rid
);

  state_e      state_r;
  owner_e      owner_r;
  logic [7:0]  beat_cnt_r;
  logic        gnt_ifu_s;
  logic        gnt_lsu_s;
  logic        own_ifu_s;
  logic        own_lsu_s;
  logic        in_ar_s;
  logic        in_r_s;
  logic        rready_s;
  logic        beat_s;
  logic        upd_en_s;
  logic [7:0]  perf_code_s;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rstn    (rstn),
    .req_ifu (ifu_arvalid),
    .req_lsu (lsu_arvalid),
    .upd_en  (upd_en_s),
    .upd_lsu (own_lsu_s),
    .gnt_ifu (gnt_ifu_s),
    .gnt_lsu (gnt_lsu_s)
  );

  // Handshake and R-channel routing: pure pass-through gated by state and owner.
  always_comb begin
    in_ar_s     = (state_r == S_AR);
    in_r_s      = (state_r == S_R);
    own_ifu_s   = (owner_r == OWN_IFU);
    own_lsu_s   = (owner_r == OWN_LSU);
    ifu_arready = in_ar_s && own_ifu_s && mem_arready;
    lsu_arready = in_ar_s && own_lsu_s && mem_arready;
    rready_s    = in_r_s && ((own_ifu_s && ifu_rready) || (own_lsu_s && lsu_rready));
    mem_rready  = rready_s;
    beat_s      = in_r_s && mem_rvalid && rready_s;
    upd_en_s    = beat_s && mem_rlast;
    ifu_rvalid  = in_r_s && own_ifu_s && mem_rvalid;
    lsu_rvalid  = in_r_s && own_lsu_s && mem_rvalid;
    if (in_r_s && own_ifu_s) begin
      ifu_rdata = mem_rdata;
      ifu_rresp = mem_rresp;
      ifu_rlast = mem_rlast;
    end else begin
      ifu_rdata = {DATA_W{1'b0}};
      ifu_rresp = 2'b00;
      ifu_rlast = 1'b0;
    end
    if (in_r_s && own_lsu_s) begin
      lsu_rdata = mem_rdata;
      lsu_rresp = mem_rresp;
      lsu_rlast = mem_rlast;
    end else begin
      lsu_rdata = {DATA_W{1'b0}};
      lsu_rresp = 2'b00;
      lsu_rlast = 1'b0;
    end
    if ((ifu_arvalid && !own_ifu_s) || (lsu_arvalid && !own_lsu_s)) begin
      perf_code_s = PERF_ARB_WAIT;
    end else begin
      perf_code_s = 8'h00;
    end
  end

  // Control FSM with the latched AR request; the payload stays put through R so arlen is kept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= S_IDLE;
      owner_r     <= OWN_NONE;
      beat_cnt_r  <= 8'd0;
      mem_arvalid <= 1'b0;
      mem_araddr  <= {ADDR_W{1'b0}};
      mem_arsize  <= 3'd0;
      mem_arlen   <= 8'd0;
      mem_arburst <= 2'd0;
      mem_arid    <= {ID_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (gnt_lsu_s) begin
            owner_r     <= OWN_LSU;
            mem_arvalid <= 1'b1;
            mem_araddr  <= lsu_araddr;
            mem_arsize  <= lsu_arsize;
            mem_arlen   <= lsu_arlen;
            mem_arburst <= lsu_arburst;
            mem_arid    <= ID_W'(owner_id(OWN_LSU));
            state_r     <= S_AR;
          end else if (gnt_ifu_s) begin
            owner_r     <= OWN_IFU;
            mem_arvalid <= 1'b1;
            mem_araddr  <= ifu_araddr;
            mem_arsize  <= ifu_arsize;
            mem_arlen   <= ifu_arlen;
            mem_arburst <= ifu_arburst;
            mem_arid    <= ID_W'(owner_id(OWN_IFU));
            state_r     <= S_AR;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_AR: begin
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            beat_cnt_r  <= 8'd0;
            state_r     <= S_R;
          end else begin
            state_r <= S_AR;
          end
        end
        S_R: begin
          if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
            if (mem_rlast) begin
              state_r <= S_IDLE;
              owner_r <= OWN_NONE;
            end else begin
              state_r <= S_R;
            end
          end else begin
            state_r <= S_R;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          owner_r     <= OWN_NONE;
          mem_arvalid <= 1'b0;
        end
      endcase
    end
  end

  axi_rd_arbiter_chk #(.ID_W(ID_W)) u_chk (
    .clk        (clk),
    .rstn       (rstn),
    .state      (state_r),
    .mem_rvalid (mem_rvalid),
    .mem_rready (rready_s),
    .mem_rlast  (mem_rlast),
    .mem_rresp  (mem_rresp),
    .mem_rid    (mem_rid),
    .own_id     (ID_W'(owner_id(owner_r))),
    .beat_cnt   (beat_cnt_r),
    .arlen      (mem_arlen),
    .perf_code  (perf_code_s)
  );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
  logic [31:0] ifu_araddr;
  logic [2:0]  ifu_arsize;
  logic [7:0]  ifu_arlen;
  logic [1:0]  ifu_arburst, ifu_rresp;
  logic [63:0] ifu_rdata;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic [7:0]  lsu_arlen;
  logic [1:0]  lsu_arburst, lsu_rresp;
  logic [63:0] lsu_rdata;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready, mem_rlast;
  logic [31:0] mem_araddr;
  logic [2:0]  mem_arsize;
  logic [7:0]  mem_arlen;
  logic [1:0]  mem_arburst, mem_rresp;
  logic [3:0]  mem_arid, mem_rid;
  logic [63:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .rstn(rstn),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_arsize(ifu_arsize), .ifu_arlen(ifu_arlen), .ifu_arburst(ifu_arburst),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_arsize(lsu_arsize), .lsu_arlen(lsu_arlen), .lsu_arburst(lsu_arburst),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arsize(mem_arsize), .mem_arlen(mem_arlen), .mem_arburst(mem_arburst),
    .mem_arid(mem_arid), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rlast(mem_rlast), .mem_rid(mem_rid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_arvalid = 1'b0; ifu_araddr = 32'h0; ifu_arsize = 3'd0; ifu_arlen = 8'd0;
    ifu_arburst = 2'd0; ifu_rready = 1'b0;
    lsu_arvalid = 1'b0; lsu_araddr = 32'h0; lsu_arsize = 3'd0; lsu_arlen = 8'd0;
    lsu_arburst = 2'd0; lsu_rready = 1'b0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0; mem_rresp = 2'b00;
    mem_rlast = 1'b0; mem_rid = 4'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    mem_arready = 1'b1; mem_rvalid = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
    lsu_arvalid = 1'b1; ifu_arvalid = 1'b1;
    tick();
    tick();
    checks++; if (mem_arvalid !== 1'b0) begin failures++; $display("FAIL rst_mem_arvalid got=%0h exp=0", mem_arvalid); end
    checks++; if ({ifu_arready, lsu_arready} !== 2'b00) begin failures++; $display("FAIL rst_arready got=%0b exp=00", {ifu_arready, lsu_arready}); end
    checks++; if ({ifu_rvalid, lsu_rvalid, mem_rready} !== 3'b000) begin failures++; $display("FAIL rst_rvalid_rready got=%0b exp=000", {ifu_rvalid, lsu_rvalid, mem_rready}); end
    checks++; if ({mem_araddr, mem_arlen, mem_arid} !== 44'h0) begin failures++; $display("FAIL rst_payload got=%0h exp=0", {mem_araddr, mem_arlen, mem_arid}); end
    idle_inputs();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_lsu_single();
    do_reset();
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0004; lsu_arlen = 8'd0;
    lsu_arsize = 3'd3; lsu_arburst = 2'd1;
    #1;
    checks++; if (lsu_arready !== 1'b0) begin failures++; $display("FAIL t1_idle_arready got=%0h exp=0", lsu_arready); end
    tick();
    checks++; if (mem_arvalid !== 1'b1) begin failures++; $display("FAIL t1_arvalid got=%0h exp=1", mem_arvalid); end
    checks++; if (mem_arid !== 4'd1) begin failures++; $display("FAIL t1_arid got=%0h exp=1", mem_arid); end
    checks++; if (mem_araddr !== 32'h8000_0004) begin failures++; $display("FAIL t1_araddr got=%0h exp=80000004", mem_araddr); end
    mem_arready = 1'b1;
    #1;
    checks++; if ({ifu_arready, lsu_arready} !== 2'b01) begin failures++; $display("FAIL t1_arready got=%0b exp=01", {ifu_arready, lsu_arready}); end
    tick();
    lsu_arvalid = 1'b0; mem_arready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h1122334455667788; mem_rlast = 1'b1; mem_rid = 4'd1;
    lsu_rready = 1'b1;
    #1;
    checks++; if (mem_arvalid !== 1'b0) begin failures++; $display("FAIL t1_arvalid_drop got=%0h exp=0", mem_arvalid); end
    checks++; if (lsu_rdata !== 64'h1122334455667788) begin failures++; $display("FAIL t1_rdata got=%0h exp=1122334455667788", lsu_rdata); end
    checks++; if ({lsu_rvalid, lsu_rlast, mem_rready} !== 3'b111) begin failures++; $display("FAIL t1_rvalid_rlast got=%0b exp=111", {lsu_rvalid, lsu_rlast, mem_rready}); end
    checks++; if ({ifu_rvalid, ifu_rdata} !== 65'h0) begin failures++; $display("FAIL t1_ifu_quiet got=%0h exp=0", {ifu_rvalid, ifu_rdata}); end
    tick();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    #1;
    checks++; if (lsu_rvalid !== 1'b0) begin failures++; $display("FAIL t1_rvalid_after got=%0h exp=0", lsu_rvalid); end
  endtask

  task automatic test_both_rr();
    do_reset();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_1000;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_2000;
    tick();
    checks++; if ({mem_arid, mem_araddr} !== {4'd1, 32'h0000_2000}) begin failures++; $display("FAIL t2_first_lsu got=%0h exp=100002000", {mem_arid, mem_araddr}); end
    mem_arready = 1'b1;
    #1;
    checks++; if ({ifu_arready, lsu_arready} !== 2'b01) begin failures++; $display("FAIL t2_arready got=%0b exp=01", {ifu_arready, lsu_arready}); end
    tick();
    lsu_arvalid = 1'b0; mem_arready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h5555; mem_rlast = 1'b1; mem_rid = 4'd1; lsu_rready = 1'b1;
    #1;
    checks++; if (ifu_arready !== 1'b0) begin failures++; $display("FAIL t2_held_off got=%0h exp=0", ifu_arready); end
    tick();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    #1;
    checks++; if (mem_arvalid !== 1'b0) begin failures++; $display("FAIL t2_no_grant_on_last got=%0h exp=0", mem_arvalid); end
    tick();
    checks++; if ({mem_arvalid, mem_arid, mem_araddr} !== {1'b1, 4'd0, 32'h0000_1000}) begin failures++; $display("FAIL t2_ifu_next got=%0h exp=100001000", {mem_arvalid, mem_arid, mem_araddr}); end
    mem_arready = 1'b1;
    tick();
    ifu_arvalid = 1'b0; mem_arready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h6666; mem_rlast = 1'b1; mem_rid = 4'd0; ifu_rready = 1'b1;
    #1;
    checks++; if ({ifu_rvalid, ifu_rdata} !== {1'b1, 64'h6666}) begin failures++; $display("FAIL t2_ifu_rdata got=%0h exp=10000000000006666", {ifu_rvalid, ifu_rdata}); end
    tick();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    tick();
    checks++; if (mem_arid !== 4'd1) begin failures++; $display("FAIL t2_prio_back_lsu got=%0h exp=1", mem_arid); end
  endtask

  task automatic test_ifu_burst();
    do_reset();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_0040; ifu_arlen = 8'd3; ifu_arburst = 2'd1;
    tick();
    checks++; if ({mem_arid, mem_arlen} !== {4'd0, 8'd3}) begin failures++; $display("FAIL t3_ar got=%0h exp=003", {mem_arid, mem_arlen}); end
    mem_arready = 1'b1;
    tick();
    ifu_arvalid = 1'b0; mem_arready = 1'b0; ifu_rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1'b1; mem_rdata = 64'hA0 + 64'(b); mem_rlast = (b == 3); mem_rid = 4'd0;
      #1;
      checks++; if ({ifu_rvalid, ifu_rdata} !== {1'b1, 64'hA0 + 64'(b)}) begin failures++; $display("FAIL t3_beat%0d got=%0h exp=%0h", b, ifu_rdata, 64'hA0 + 64'(b)); end
      checks++; if (ifu_rlast !== (b == 3)) begin failures++; $display("FAIL t3_rlast%0d got=%0h exp=%0h", b, ifu_rlast, (b == 3)); end
      tick();
      mem_rvalid = 1'b0; mem_rlast = 1'b0;
      if (b < 3) begin
        for (int g = 0; g < 2; g++) begin
          #1;
          checks++; if (ifu_rvalid !== 1'b0) begin failures++; $display("FAIL t3_gap%0d_%0d got=%0h exp=0", b, g, ifu_rvalid); end
          tick();
        end
      end
    end
    #1;
    checks++; if (dut.state_r !== S_IDLE) begin failures++; $display("FAIL t3_idle_after got=%0h exp=%0h", dut.state_r, S_IDLE); end
  endtask

  task automatic test_rready_stall();
    do_reset();
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_0300;
    tick();
    mem_arready = 1'b1;
    tick();
    lsu_arvalid = 1'b0; mem_arready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0001; mem_rlast = 1'b1; mem_rid = 4'd1;
    lsu_rready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({mem_rready, lsu_rvalid, lsu_rdata} !== {1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001}) begin failures++; $display("FAIL t4_stall%0d got=%0h exp=1deadbeef00000001", c, {mem_rready, lsu_rvalid, lsu_rdata}); end
      tick();
    end
    lsu_rready = 1'b1;
    #1;
    checks++; if (mem_rready !== 1'b1) begin failures++; $display("FAIL t4_release got=%0h exp=1", mem_rready); end
    tick();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    #1;
    checks++; if (dut.state_r !== S_IDLE) begin failures++; $display("FAIL t4_idle got=%0h exp=%0h", dut.state_r, S_IDLE); end
  endtask

  task automatic test_ar_hold();
    int pulses;
    pulses = 0;
    do_reset();
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_0100;
    tick();
    for (int c = 0; c < 3; c++) begin
      lsu_araddr = 32'h0000_0200 + 32'(c * 4);
      #1;
      checks++; if ({mem_arvalid, mem_araddr} !== {1'b1, 32'h0000_0100}) begin failures++; $display("FAIL t5_hold%0d got=%0h exp=100000100", c, {mem_arvalid, mem_araddr}); end
      if (lsu_arready) pulses++;
      tick();
    end
    mem_arready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (lsu_arready) pulses++;
      tick();
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL t5_pulses got=%0d exp=1", pulses); end
    lsu_arvalid = 1'b0; mem_arready = 1'b0;
    mem_rvalid = 1'b1; mem_rlast = 1'b1; mem_rid = 4'd1; lsu_rready = 1'b1;
    tick();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    ifu_arvalid = 1'b1; ifu_arlen = 8'd3;
    tick();
    mem_arready = 1'b1;
    tick();
    ifu_arvalid = 1'b0; ifu_rready = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h77; mem_rid = 4'd0;
    tick();
    #1;
    checks++; if (ifu_rvalid !== 1'b1) begin failures++; $display("FAIL t6_pre got=%0h exp=1", ifu_rvalid); end
    rstn = 1'b0;
    #1;
    checks++; if ({mem_arvalid, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, mem_rready} !== 6'b0) begin failures++; $display("FAIL t6_async got=%0b exp=000000", {mem_arvalid, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, mem_rready}); end
    idle_inputs();
    tick();
    tick();
    rstn = 1'b1;
    tick();
    checks++; if (dut.state_r !== S_IDLE) begin failures++; $display("FAIL t6_idle got=%0h exp=%0h", dut.state_r, S_IDLE); end
    ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_0A00;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_0B00;
    tick();
    ifu_arvalid = 1'b0;
    checks++; if ({mem_arid, mem_araddr} !== {4'd1, 32'h0000_0B00}) begin failures++; $display("FAIL t6_lsu_first got=%0h exp=100000b00", {mem_arid, mem_araddr}); end
    mem_arready = 1'b1;
    tick();
    lsu_arvalid = 1'b0; mem_arready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h99; mem_rlast = 1'b1; mem_rid = 4'd1; lsu_rready = 1'b1;
    #1;
    checks++; if ({lsu_rvalid, lsu_rdata} !== {1'b1, 64'h99}) begin failures++; $display("FAIL t6_lsu_rdata got=%0h exp=10000000000000099", {lsu_rvalid, lsu_rdata}); end
    tick();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    tick();
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    test_reset();
    test_lsu_single();
    test_both_rr();
    test_ifu_burst();
    test_rready_stall();
    test_ar_hold();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Read-channel arbiter sitting directly downstream of the LSU read master and the IFU fetch master.
- Merges both AXI read masters onto the single memory-side AXI read port, one transaction outstanding at a time.
- Round-robin between the two masters, with bursts permitted (IFU line fills), and routes R beats back to the owner.
- The LSU write channel bypasses this block.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, read data width (matches the LSU 64-bit bus)
ID_W, 4, memory-side ARID/RID width

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
ifu_arvalid/ifu_arready  in/out  1/1  IFU AR handshake
ifu_araddr/ifu_arsize/ifu_arlen/ifu_arburst  in  ADDR_W/3/8/2  IFU AR payload
ifu_rvalid/ifu_rready  out/in  1/1  IFU R handshake
ifu_rdata/ifu_rresp/ifu_rlast  out  DATA_W/2/1  IFU R payload
lsu_arvalid/lsu_arready  in/out  1/1  LSU AR handshake
lsu_araddr/lsu_arsize/lsu_arlen/lsu_arburst  in  ADDR_W/3/8/2  LSU AR payload
lsu_rvalid/lsu_rready  out/in  1/1  LSU R handshake
lsu_rdata/lsu_rresp/lsu_rlast  out  DATA_W/2/1  LSU R payload
mem_arvalid/mem_arready  out/in  1/1  memory AR handshake
mem_araddr/mem_arsize/mem_arlen/mem_arburst/mem_arid  out  ADDR_W/3/8/2/ID_W  memory AR payload
mem_rvalid/mem_rready  in/out  1/1  memory R handshake
mem_rdata/mem_rresp/mem_rlast/mem_rid  in  DATA_W/2/1/ID_W  memory R payload

Behaviour:
- Clock and reset: one clock `clk`; reset `rstn` is asynchronous and active-low.
- Reset state:
  - state=IDLE, owner=NONE, prio=LSU (LSU wins first tie).
  - All *_valid/*_ready outputs are 0.
  - All payload outputs are 0.
- FSM states: IDLE, AR, R.
- IDLE:
  - Sample ifu_arvalid and lsu_arvalid.
  - If only one is high, that master wins.
  - If both are high, the prio master wins.
  - Latch the winner's AR payload into a register and go to AR.
  - No arready is asserted in IDLE.
  - Minimum latency: request cycle N → mem_arvalid at N+1.
- AR:
  - mem_arvalid=1, driven with the latched payload.
  - mem_arid: 0 for IFU, 1 for LSU.
  - The owner's arready mirrors mem_arready; the non-owner's arready is 0.
  - On mem_arvalid&mem_arready, go to R. The owner's handshake completes in the same cycle.
  - Payload is held stable while waiting, regardless of upstream changes.
  - If the owner drops arvalid before the handshake (AXI violation), the latched request is still issued.
- R:
  - The owner's rvalid/rdata/rresp/rlast mirror mem_*; mem_rready mirrors the owner's rready.
  - The non-owner's rvalid is 0 and its rdata is 0.
  - Each beat is counted. On a beat with mem_rlast=1:
    - go to IDLE;
    - prio flips to the other master;
    - owner=NONE.
  - A new grant is possible in the cycle after the last beat. The last beat cycle itself never grants.
- Combinational paths: arready and R fields are combinational pass-through from the memory side; there are no added bubbles within a burst.
- Error and protocol checks:
  - rresp≠OKAY is forwarded unchanged; no retry.
  - Simulation-only: flag mem_rid≠owner id.
  - Simulation-only: flag a beat count ≠ arlen+1 at rlast.
  - Simulation-only: flag mem_rvalid while in IDLE or AR.
- Beat counter: 8 bits, clears on entry to R. Wrap is impossible because arlen ≤ 255.
- Simultaneous events: a new request from the non-owner during R is held off (arready=0) and is granted next if still valid, since prio has flipped.
- Reset mid-operation (rstn low in AR or R): outputs drop to 0 asynchronously and the FSM returns to IDLE. Any outstanding memory beat is not tracked; the system resets memory together with the arbiter.
- Perf, simulation-only: perf_event(PERF_ARB_WAIT) on each cycle a valid requester is not the owner.

Decomposition:
- Shared package holds:
  - owner_e enum {OWN_NONE, OWN_IFU, OWN_LSU};
  - state_e enum {S_IDLE, S_AR, S_R};
  - ID constants ARB_ID_IFU=0, ARB_ID_LSU=1;
  - AXI resp constants (OKAY=2'b00);
  - the PERF_ARB_WAIT code.
- One natural sub-module: rr_arbiter2, a 2-way round-robin grant with registered priority and an update-enable input.
- The FSM and routing stay in the top.

Test Plan:
1. Only the LSU requests, araddr=0x8000_0004, arlen=0: mem_arvalid at +1 cycle with arid=1; the single rdata beat 0x1122334455667788 with rlast appears on lsu_rdata; ifu_rvalid stays 0.
2. IFU and LSU both raise arvalid in the same cycle after reset: the LSU is granted first. After its rlast, the IFU is granted the cycle after IDLE, and prio becomes LSU.
3. IFU burst, arlen=3, with memory inserting 2 idle cycles between beats: 4 beats are delivered in order, ifu_rlast only on the 4th, and the FSM is in IDLE on the cycle after.
4. Owner rready held low for 5 cycles with mem_rvalid=1: mem_rready stays 0 and mem_rdata is held; the beat transfers on the first cycle rready=1.
5. mem_arready held low for 3 cycles while the LSU changes araddr: mem_araddr stays at the latched value; lsu_arready pulses exactly once.
6. rstn asserted low mid-burst in R: all valid/ready outputs are 0 immediately. After release the state is IDLE, and a fresh LSU request is serviced normally with prio=LSU.
